// File: rtl/bpm_event_capture.sv
// Pre/post-trigger multi-channel capture buffer with valid/ready readout.
// Optional BPM_CAPTURE_TSTAMP_EN builds a sample counter latched into out_tstamp.
module bpm_event_capture #(
  parameter int DW    = 16,
  parameter int NCH   = 4,
  parameter int DEPTH = 1024,
  parameter int PRE   = 10,
  parameter int WIN   = 100
) (
  input  logic              wr_clk,
  input  logic              rst,
  input  logic [NCH*DW-1:0] din,
  input  logic              din_valid,
  input  logic              trig,
  input  logic              arm,
  input  logic              auto_rearm,
  output logic [NCH*DW-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [31:0]       out_tstamp,
  output logic [1:0]        state,
  output logic [7:0]        trig_miss
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WIN + 1);
  localparam logic [CW-1:0] PRE_C  = CW'(PRE);
  localparam logic [CW-1:0] POST_C = CW'(WIN - PRE);
  localparam logic [CW-1:0] WIN_C  = CW'(WIN);
  localparam logic [AW-1:0] PRE_A  = AW'(PRE);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_ARMED, S_CAPT, S_READ} fsm_t;

  fsm_t              fsm_q;
  logic [1:0]        state_q;
  logic              trig_q;
  logic [AW-1:0]     wp_q, wp_d;
  logic [AW-1:0]     rd_ptr_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     rd_left_q;
  logic              rd_go_q;
  logic [7:0]        miss_q;
  logic [NCH*DW-1:0] out_data_q;
  logic              out_valid_q, out_last_q;
  logic [NCH*DW-1:0] ram [DEPTH];

  logic edge_det, wr_en, load, accept;

  assign edge_det = trig & ~trig_q;
  assign accept   = edge_det && (fsm_q == S_ARMED);
  assign wr_en    = din_valid && (fsm_q == S_FILL || fsm_q == S_ARMED || fsm_q == S_CAPT);
  assign wp_d     = wp_q + AW'(1);
  assign cnt_d    = cnt_q + CW'(1);
  // rd_go_q inserts the extra cycle between the last write and the first read
  assign load     = rd_go_q && (rd_left_q != '0) && (!out_valid_q || out_ready);

  always_ff @(posedge wr_clk) begin
    if (wr_en) ram[wp_q] <= din;
  end

  always_ff @(posedge wr_clk or negedge rst) begin
    if (!rst) begin
      fsm_q       <= S_IDLE;
      state_q     <= 2'd0;
      trig_q      <= 1'b0;
      wp_q        <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rd_left_q   <= '0;
      rd_go_q     <= 1'b0;
      miss_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      trig_q <= trig;
      if (edge_det && !accept && miss_q != 8'hFF) miss_q <= miss_q + 8'd1;
      if (wr_en) wp_q <= wp_d;
      case (fsm_q)
        S_IDLE: if (arm) begin
          fsm_q   <= S_FILL;
          state_q <= 2'd1;
          cnt_q   <= '0;
        end
        S_FILL: if (din_valid) begin
          cnt_q <= cnt_d;
          if (cnt_d == PRE_C) begin
            fsm_q   <= S_ARMED;
            state_q <= 2'd2;
          end
        end
        S_ARMED: if (edge_det) begin
          rd_ptr_q  <= wp_q - PRE_A;
          rd_left_q <= WIN_C;
          rd_go_q   <= 1'b0;
          cnt_q     <= din_valid ? CW'(1) : CW'(0);
          state_q   <= 2'd3;
          fsm_q     <= (din_valid && POST_C == CW'(1)) ? S_READ : S_CAPT;
        end
        S_CAPT: if (din_valid) begin
          cnt_q <= cnt_d;
          if (cnt_d == POST_C) fsm_q <= S_READ;
        end
        S_READ: begin
          if (!rd_go_q) begin
            rd_go_q <= 1'b1;
          end else if (out_valid_q && out_ready && out_last_q) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            cnt_q       <= '0;
            fsm_q       <= auto_rearm ? S_FILL : S_IDLE;
            state_q     <= auto_rearm ? 2'd1 : 2'd0;
          end else if (load) begin
            out_data_q  <= ram[rd_ptr_q];
            rd_ptr_q    <= rd_ptr_q + AW'(1);
            rd_left_q   <= rd_left_q - CW'(1);
            out_valid_q <= 1'b1;
            out_last_q  <= (rd_left_q == CW'(1));
          end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
          end
        end
        default: begin
          fsm_q   <= S_IDLE;
          state_q <= 2'd0;
        end
      endcase
    end
  end

`ifdef BPM_CAPTURE_TSTAMP_EN
  logic [31:0] ts_cnt_q, out_tstamp_q;

  always_ff @(posedge wr_clk or negedge rst) begin
    if (!rst) begin
      ts_cnt_q     <= '0;
      out_tstamp_q <= '0;
    end else begin
      if (din_valid) ts_cnt_q <= ts_cnt_q + 32'd1;
      if (accept) out_tstamp_q <= ts_cnt_q;
    end
  end

  assign out_tstamp = out_tstamp_q;
`else
  assign out_tstamp = '0;
`endif

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign state     = state_q;
  assign trig_miss = miss_q;
endmodule

// File: tb/tb_bpm_event_capture.sv
// Bench for bpm_event_capture: mode/queue reference model checked every cycle,
// plus hand-computed literal expectations for the directed scenarios.
`timescale 1ns/1ps
module tb_bpm_event_capture;
  localparam int DW = 16, NCH = 4, DEPTH = 16, PRE = 4, WIN = 16;
  localparam int W = NCH * DW;
`ifdef BPM_CAPTURE_TSTAMP_EN
  localparam logic [31:0] EXP_TS999 = 32'd999;
`else
  localparam logic [31:0] EXP_TS999 = 32'd0;
`endif

  logic          wr_clk = 1'b0, rst = 1'b0;
  logic [W-1:0]  din = '0;
  logic          din_valid = 1'b0, trig = 1'b0, arm = 1'b0, auto_rearm = 1'b1, out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic          out_valid, out_last;
  logic [31:0]   out_tstamp;
  logic [1:0]    state;
  logic [7:0]    trig_miss;

  bpm_event_capture #(.DW(DW), .NCH(NCH), .DEPTH(DEPTH), .PRE(PRE), .WIN(WIN)) dut (
    .wr_clk(wr_clk), .rst(rst), .din(din), .din_valid(din_valid), .trig(trig), .arm(arm),
    .auto_rearm(auto_rearm), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_tstamp(out_tstamp), .state(state), .trig_miss(trig_miss));

  always #5 wr_clk = ~wr_clk;

  int n_cmp = 0, n_err = 0;
  int n = 0;
  bit rnd_ready = 1'b0;
  logic [W-1:0] rx[$];
  bit rx_last[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: acquisition mode plus a history queue of recorded samples
  typedef enum int {M_IDLE, M_FILL, M_ARMED, M_CAPT, M_READ} mmode_t;
  mmode_t       m_mode = M_IDLE;
  int           m_fill, m_post, m_delay, m_idx, m_miss;
  bit           m_valid, m_trig_r, m_edge;
  logic [31:0]  m_ts, m_tstamp;
  logic [W-1:0] hist[$];
  logic [W-1:0] win[$];

  function automatic logic [1:0] mstate();
    case (m_mode)
      M_IDLE:  return 2'd0;
      M_FILL:  return 2'd1;
      M_ARMED: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [W-1:0] ramp(input int k);
    logic [W-1:0] r;
    for (int c = 0; c < NCH; c++) r[c*DW +: DW] = 16'(c * 4096 + k);
    return r;
  endfunction

  task record(input logic [W-1:0] s);
    hist.push_back(s);
    if (hist.size() > 64) void'(hist.pop_front());
  endtask

  task start_read();
    win.delete();
    for (int i = hist.size() - WIN; i < hist.size(); i++) win.push_back(hist[i]);
    m_mode = M_READ; m_idx = 0; m_delay = 2; m_valid = 1'b0;
  endtask

  always @(posedge wr_clk or negedge rst) begin
    if (!rst) begin
      m_mode = M_IDLE; m_fill = 0; m_post = 0; m_delay = 0; m_idx = 0; m_miss = 0;
      m_valid = 1'b0; m_trig_r = 1'b0; m_ts = '0; m_tstamp = '0;
      hist.delete(); win.delete();
    end else begin
      m_edge = trig && !m_trig_r;
      m_trig_r = trig;
      if (m_edge && m_mode != M_ARMED && m_miss < 255) m_miss++;
      case (m_mode)
        M_IDLE: if (arm) begin m_mode = M_FILL; m_fill = 0; end
        M_FILL: if (din_valid) begin
          record(din); m_fill++;
          if (m_fill == PRE) m_mode = M_ARMED;
        end
        M_ARMED: begin
          if (m_edge) begin m_tstamp = m_ts; m_post = 0; m_mode = M_CAPT; end
          if (din_valid) begin record(din); if (m_mode == M_CAPT) m_post++; end
          if (m_mode == M_CAPT && m_post == WIN - PRE) start_read();
        end
        M_CAPT: if (din_valid) begin
          record(din); m_post++;
          if (m_post == WIN - PRE) start_read();
        end
        M_READ: begin
          if (m_valid && out_ready) begin
            m_idx++;
            if (m_idx == WIN) begin
              m_valid = 1'b0; m_fill = 0;
              m_mode = auto_rearm ? M_FILL : M_IDLE;
            end
          end else if (!m_valid) begin
            m_delay--;
            if (m_delay == 0) m_valid = 1'b1;
          end
        end
        default: m_mode = M_IDLE;
      endcase
      if (din_valid) m_ts++;
    end
  end

  always @(posedge wr_clk) begin
    #2;
    if (rst) begin
      chk("state", state, mstate());
      chk("trig_miss", trig_miss, m_miss);
      chk("out_valid", out_valid, m_valid);
      if (m_valid) begin
        chk("out_data", out_data, win[m_idx]);
        chk("out_last", out_last, m_idx == WIN - 1);
`ifdef BPM_CAPTURE_TSTAMP_EN
        chk("out_tstamp", out_tstamp, m_tstamp);
`else
        chk("out_tstamp", out_tstamp, 0);
`endif
      end else begin
        chk("out_last_idle", out_last, 0);
      end
      if (out_valid && out_ready) begin
        rx.push_back(out_data);
        rx_last.push_back(out_last);
      end
    end
  end

  task automatic cyc(input bit dv, input bit tg, input bit am);
    @(negedge wr_clk);
    din_valid = dv; trig = tg; arm = am;
    if (dv) begin din = ramp(n); n++; end
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic drain(input bit dv, input int budget);
    int k = 0;
    while ((m_mode == M_CAPT || m_mode == M_READ) && k < budget) begin
      cyc(dv, 1'b0, 1'b0);
      k++;
    end
    if (m_mode == M_CAPT || m_mode == M_READ) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: still busy after %0d cycles, expected readout complete", budget);
    end
  endtask

  task automatic capture_window(input int extra_pre);
    repeat (PRE + extra_pre) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    repeat (WIN - PRE - 1) cyc(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int base, k;
    bit rpat[8] = '{1, 0, 1, 0, 1, 0, 1, 0};
    bit cpat[11] = '{0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0};

    repeat (3) @(negedge wr_clk);
    chk("reset_state", state, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_last", out_last, 0);
    chk("reset_data", out_data, 0);
    chk("reset_tstamp", out_tstamp, 0);
    chk("reset_miss", trig_miss, 0);
    rst = 1'b1;

    // Edge at sample 50: start = (50 mod 16) - 4 = 14, window n = 46..61
    auto_rearm = 1'b1;
    cyc(1'b0, 1'b0, 1'b1);
    repeat (50) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    repeat (WIN - PRE - 1) cyc(1'b1, 1'b0, 1'b0);
    drain(1'b1, 100);
    chk("win1_count", 64'(rx.size()), 16);
    chk("win1_first", rx[0], 64'h302E_202E_102E_002E);
    chk("win1_final", rx[15], 64'h303D_203D_103D_003D);
    chk("win1_last_flag", rx_last[15], 1);
    chk("win1_not_last", rx_last[14], 0);
    for (int i = 0; i < WIN; i++) chk("win1_ramp", rx[i], ramp(46 + i));
    chk("rearm_state", state, 1);

    // Missed edges: 2 in FILL, 3 in CAPTURE, 4 in READOUT; random backpressure
    rnd_ready = 1'b1;
    cyc(1'b0, 1'b1, 1'b0); cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0); cyc(1'b0, 1'b0, 1'b0);
    repeat (6) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 11; i++) cyc(1'b1, cpat[i], 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b0, rpat[i], 1'b0);
    drain(1'b0, 300);
    chk("miss_9", trig_miss, 9);
    chk("win2_count", 64'(rx.size()), 32);
    chk("rearm_state2", state, 1);
    rnd_ready = 1'b0;

    // No auto re-arm: IDLE after last; unarmed edge ignored; arm+edge same cycle
    auto_rearm = 1'b0;
    capture_window(1);
    drain(1'b1, 100);
    chk("idle_after_last", state, 0);
    cyc(1'b1, 1'b1, 1'b0);
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    chk("no_arm_state", state, 0);
    chk("no_arm_miss", trig_miss, 10);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("arm_edge_state", state, 1);
    chk("arm_edge_miss", trig_miss, 11);
    base = rx.size();
    capture_window(1);
    drain(1'b1, 100);
    chk("win4_count", 64'(rx.size()), 64'(base + 16));
    chk("win4_idle", state, 0);

    // Saturation of the missed-edge counter
    repeat (300) begin cyc(1'b0, 1'b1, 1'b0); cyc(1'b0, 1'b0, 1'b0); end
    chk("miss_sat", trig_miss, 255);

    // Edge on the 1000th valid sample, then reset in the middle of readout
    cyc(1'b0, 1'b0, 1'b1);
    while (n < 999) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    repeat (WIN - PRE - 1) cyc(1'b1, 1'b0, 1'b0);
    base = rx.size();
    k = 0;
    while (rx.size() < base + 10 && k < 100) begin cyc(1'b0, 1'b0, 1'b0); k++; end
    chk("ts_win_progress", 64'(rx.size() >= base + 10), 1);
    chk("ts_win_first", rx[base], 64'h33E3_23E3_13E3_03E3);
    chk("tstamp_999", out_tstamp, EXP_TS999);
    chk("mid_read_valid", out_valid, 1);
    @(negedge wr_clk);
    rst = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_state", state, 0);
    chk("async_rst_data", out_data, 0);
    chk("async_rst_last", out_last, 0);
    chk("async_rst_miss", trig_miss, 0);
    chk("async_rst_tstamp", out_tstamp, 0);
    n = 0;
    repeat (2) @(negedge wr_clk);
    rst = 1'b1;

    // Recovery capture after reset
    auto_rearm = 1'b1;
    cyc(1'b0, 1'b0, 1'b1);
    capture_window(2);
    drain(1'b0, 100);
    chk("recover_state", state, 1);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end
endmodule
